// File: rtl/alu_pkg.sv
// Shared constants for the pipelined ALU: opcode encodings and the
// control FSM state type.
package alu_pkg;

    localparam logic [3:0] OP_ADD   = 4'd0;
    localparam logic [3:0] OP_SUB   = 4'd1;
    localparam logic [3:0] OP_ADDS  = 4'd2;
    localparam logic [3:0] OP_SUBS  = 4'd3;
    localparam logic [3:0] OP_AND   = 4'd4;
    localparam logic [3:0] OP_OR    = 4'd5;
    localparam logic [3:0] OP_NOT   = 4'd6;
    localparam logic [3:0] OP_SHL1  = 4'd7;
    localparam logic [3:0] OP_SLL   = 4'd8;
    localparam logic [3:0] OP_SRL   = 4'd9;
    localparam logic [3:0] OP_SRA   = 4'd10;
    localparam logic [3:0] OP_XOR   = 4'd11;
    localparam logic [3:0] OP_SLT   = 4'd12;
    localparam logic [3:0] OP_SLTU  = 4'd13;
    localparam logic [3:0] OP_MUL   = 4'd14;
    localparam logic [3:0] OP_PASSB = 4'd15;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        MUL  = 2'd1,
        OUT  = 2'd2
    } alu_state_t;

endpackage

// File: rtl/alu_if.sv
// Operation/result bus of the pipelined ALU.
//
// Handshake: a beat moves on a channel in every cycle where valid and ready
// are both high at the rising clock edge. The producer holds valid and its
// payload stable until that happens; ready may depend combinationally on the
// other channel (in_ready follows out_ready while a result is pending).
interface alu_if #(
    parameter int NUMBITS = 32
);
    logic               in_valid;
    logic               in_ready;
    logic [NUMBITS-1:0] A;
    logic [NUMBITS-1:0] B;
    logic [3:0]         opcode;
    logic               out_valid;
    logic               out_ready;
    logic [NUMBITS-1:0] result;
    logic               carryout;
    logic               overflow;
    logic               zero;
    logic               negative;

    modport master (
        output in_valid, A, B, opcode, out_ready,
        input  in_ready, out_valid, result, carryout, overflow, zero, negative
    );

    modport slave (
        input  in_valid, A, B, opcode, out_ready,
        output in_ready, out_valid, result, carryout, overflow, zero, negative
    );

endinterface

// File: rtl/alu_mul_seq.sv
// Iterative shift-add multiplier producing the low NUMBITS bits of a*b.
// The first partial product is folded in on the start edge, so the final
// product is ready NUMBITS-1 edges later, flagged by a one-cycle done pulse.
module alu_mul_seq #(
    parameter int NUMBITS = 32
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               start,
    input  logic [NUMBITS-1:0] a,
    input  logic [NUMBITS-1:0] b,
    output logic               done,
    output logic [NUMBITS-1:0] product
);
    localparam int CW = $clog2(NUMBITS + 1);
    localparam logic [CW-1:0] LAST = CW'(NUMBITS - 1);

    logic [NUMBITS-1:0] mcand;
    logic [NUMBITS-1:0] mplier;
    logic [CW-1:0]      count;
    logic               busy;

    // Load operands on start, then add one shifted multiplicand per cycle.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            product <= '0;
            mcand   <= '0;
            mplier  <= '0;
            count   <= '0;
            busy    <= 1'b0;
            done    <= 1'b0;
        end else begin
            done <= 1'b0;
            if (start) begin
                product <= b[0] ? a : '0;
                mcand   <= a << 1;
                mplier  <= b >> 1;
                count   <= CW'(1);
                busy    <= 1'b1;
            end else if (busy) begin
                product <= product + (mplier[0] ? mcand : '0);
                mcand   <= mcand << 1;
                mplier  <= mplier >> 1;
                count   <= count + CW'(1);
                if (count == LAST) begin
                    busy <= 1'b0;
                    done <= 1'b1;
                end
            end
        end
    end

endmodule

// File: rtl/alu_pipe.sv
// Single-stage ALU with valid/ready on both sides. Non-multiply ops are
// computed combinationally and registered on accept; multiply is handed to
// the sequential multiplier and the FSM waits in MUL until it finishes.
module alu_pipe
    import alu_pkg::*;
#(
    parameter int NUMBITS = 32,
    parameter int SHW     = $clog2(NUMBITS)
) (
    input  logic       clk,
    input  logic       reset,
    alu_if.slave       bus,
    output alu_state_t state
);
    localparam int MSB = NUMBITS - 1;

    logic               ready;
    logic               accept;
    logic               start_mul;
    logic [NUMBITS:0]   add_w;
    logic [NUMBITS:0]   sub_w;
    logic [SHW-1:0]     sh;
    logic [NUMBITS-1:0] alu_res;
    logic               alu_c;
    logic               alu_v;
    logic               mul_done;
    logic [NUMBITS-1:0] mul_product;

    logic               out_valid_q;
    logic [NUMBITS-1:0] result_q;
    logic               carry_q;
    logic               ovf_q;
    logic               zero_q;
    logic               neg_q;

    // A new op fits whenever nothing is pending or the pending result leaves now.
    assign ready     = !reset && ((state == IDLE) || ((state == OUT) && bus.out_ready));
    assign accept    = bus.in_valid && ready;
    assign start_mul = accept && (bus.opcode == OP_MUL);

    // Zero-extended so bit NUMBITS is the carry (add) or borrow (sub).
    assign add_w = {1'b0, bus.A} + {1'b0, bus.B};
    assign sub_w = {1'b0, bus.A} - {1'b0, bus.B};
    assign sh    = bus.B[SHW-1:0];

    // Combinational result and arithmetic flags for every non-multiply op.
    always_comb begin
        alu_res = '0;
        alu_c   = 1'b0;
        alu_v   = 1'b0;
        case (bus.opcode)
            OP_ADD:   {alu_c, alu_res} = add_w;
            OP_SUB:   {alu_c, alu_res} = sub_w;
            OP_ADDS: begin
                alu_res = add_w[MSB:0];
                alu_v   = (bus.A[MSB] == bus.B[MSB]) && (alu_res[MSB] != bus.A[MSB]);
            end
            OP_SUBS: begin
                alu_res = sub_w[MSB:0];
                alu_v   = (bus.A[MSB] != bus.B[MSB]) && (alu_res[MSB] != bus.A[MSB]);
            end
            OP_AND:   alu_res = bus.A & bus.B;
            OP_OR:    alu_res = bus.A | bus.B;
            OP_NOT:   alu_res = ~bus.A;
            OP_SHL1:  alu_res = bus.A << 1;
            OP_SLL:   alu_res = bus.A << sh;
            OP_SRL:   alu_res = bus.A >> sh;
            OP_SRA:   alu_res = $unsigned($signed(bus.A) >>> sh);
            OP_XOR:   alu_res = bus.A ^ bus.B;
            OP_SLT:   alu_res = {{(NUMBITS-1){1'b0}}, $signed(bus.A) < $signed(bus.B)};
            OP_SLTU:  alu_res = {{(NUMBITS-1){1'b0}}, bus.A < bus.B};
            OP_PASSB: alu_res = bus.B;
            default:  alu_res = '0;   // OP_MUL result comes from the multiplier
        endcase
    end

    alu_mul_seq #(.NUMBITS(NUMBITS)) u_mul (
        .clk     (clk),
        .reset   (reset),
        .start   (start_mul),
        .a       (bus.A),
        .b       (bus.B),
        .done    (mul_done),
        .product (mul_product)
    );

    // Control FSM with registered result, flags and out_valid.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state       <= IDLE;
            out_valid_q <= 1'b0;
            result_q    <= '0;
            carry_q     <= 1'b0;
            ovf_q       <= 1'b0;
            zero_q      <= 1'b0;
            neg_q       <= 1'b0;
        end else begin
            case (state)
                // IDLE and OUT share accept handling; in OUT accept implies out_ready.
                IDLE, OUT: begin
                    if (accept) begin
                        if (bus.opcode == OP_MUL) begin
                            state       <= MUL;
                            out_valid_q <= 1'b0;
                        end else begin
                            state       <= OUT;
                            out_valid_q <= 1'b1;
                            result_q    <= alu_res;
                            carry_q     <= alu_c;
                            ovf_q       <= alu_v;
                            zero_q      <= (alu_res == '0);
                            neg_q       <= alu_res[MSB];
                        end
                    end else if ((state == OUT) && bus.out_ready) begin
                        state       <= IDLE;
                        out_valid_q <= 1'b0;
                    end
                end
                MUL: begin
                    if (mul_done) begin
                        state       <= OUT;
                        out_valid_q <= 1'b1;
                        result_q    <= mul_product;
                        carry_q     <= 1'b0;
                        ovf_q       <= 1'b0;
                        zero_q      <= (mul_product == '0);
                        neg_q       <= mul_product[MSB];
                    end
                end
                default: begin
                    state       <= IDLE;
                    out_valid_q <= 1'b0;
                end
            endcase
        end
    end

    assign bus.in_ready  = ready;
    assign bus.out_valid = out_valid_q;
    assign bus.result    = result_q;
    assign bus.carryout  = carry_q;
    assign bus.overflow  = ovf_q;
    assign bus.zero      = zero_q;
    assign bus.negative  = neg_q;

endmodule

// File: tb/tb_alu_pipe.sv
// Bench for alu_pipe at NUMBITS=8: directed vectors with latency checks,
// back-pressure and reset-mid-multiply scenarios, then a randomized stream
// checked through an expected-result queue against an integer model.
module tb_alu_pipe;
    import alu_pkg::*;

    logic       clk;
    logic       reset;
    alu_state_t dbg_state;

    int n_tests = 0;
    int n_fail  = 0;
    int n_out   = 0;

    // {carryout, overflow, zero, negative, result}
    logic [11:0] exp_q[$];

    alu_if #(.NUMBITS(8)) bus();

    alu_pipe #(.NUMBITS(8)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus),
        .state (dbg_state)
    );

    // ---------------- clock / reset ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    // ---------------- checking ----------------
    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Integer reference model of every opcode for an 8-bit datapath.
    function automatic logic [11:0] model(input logic [3:0] op, input logic [7:0] a, input logic [7:0] b);
        int ua, ub, sa, sb, r, s, sh, p;
        logic c, v;
        logic [7:0] res;
        ua = int'(a);
        ub = int'(b);
        sa = (ua >= 128) ? ua - 256 : ua;
        sb = (ub >= 128) ? ub - 256 : ub;
        sh = ub % 8;
        p  = 1 << sh;
        c  = 1'b0;
        v  = 1'b0;
        r  = 0;
        case (op)
            4'd0:  begin r = ua + ub; c = (r > 255); end
            4'd1:  begin r = ua - ub; c = (ua < ub); end
            4'd2:  begin s = sa + sb; r = s; v = (s > 127) || (s < -128); end
            4'd3:  begin s = sa - sb; r = s; v = (s > 127) || (s < -128); end
            4'd4:  r = int'(a & b);
            4'd5:  r = int'(a | b);
            4'd6:  r = 255 - ua;
            4'd7:  r = ua * 2;
            4'd8:  r = ua * p;
            4'd9:  r = ua / p;
            4'd10: r = (sa >= 0) ? sa / p : -((-sa + p - 1) / p);
            4'd11: r = int'(a ^ b);
            4'd12: r = (sa < sb) ? 1 : 0;
            4'd13: r = (ua < ub) ? 1 : 0;
            4'd14: r = ua * ub;
            default: r = ub;
        endcase
        res = r[7:0];
        return {c, v, (res == 8'h00), res[7], res};
    endfunction

    // ---------------- scoreboard monitor ----------------
    initial begin
        logic [11:0] e;
        forever begin
            @(negedge clk);
            #4;
            if (!reset && bus.out_valid && bus.out_ready) begin
                n_out++;
                if (exp_q.size() == 0) begin
                    check("sb_output_without_op", 64'(exp_q.size()), 64'd1);
                end else begin
                    e = exp_q.pop_front();
                    check("sb_result", 64'({bus.carryout, bus.overflow, bus.zero, bus.negative, bus.result}), 64'(e));
                end
            end
        end
    end

    // ---------------- driver tasks ----------------
    // Issue one op with out_ready low, measure latency and stalled cycles,
    // capture the output, then release it for one cycle.
    task automatic do_op(input logic [3:0] op, input logic [7:0] a, input logic [7:0] b,
                         output int lat, output int stall, output logic [11:0] obs);
        int guard;
        lat   = 0;
        stall = 0;
        guard = 0;
        @(negedge clk);
        bus.in_valid  = 1'b1;
        bus.opcode    = op;
        bus.A         = a;
        bus.B         = b;
        bus.out_ready = 1'b0;
        #4;
        while (!bus.in_ready && guard < 50) begin
            @(negedge clk);
            #4;
            guard++;
        end
        check("drv_accept", 64'(bus.in_ready), 64'd1);
        if (bus.in_ready) exp_q.push_back(model(op, a, b));
        @(negedge clk);
        bus.in_valid = 1'b0;
        #4;
        lat = 1;
        while (!bus.out_valid && lat < 50) begin
            if (!bus.in_ready) stall++;
            @(negedge clk);
            #4;
            lat++;
        end
        obs = {bus.carryout, bus.overflow, bus.zero, bus.negative, bus.result};
        @(negedge clk);
        bus.out_ready = 1'b1;
        @(negedge clk);
        bus.out_ready = 1'b0;
    endtask

    // ---------------- main sequence ----------------
    logic [3:0]  d_op [8] = '{4'd0, 4'd2, 4'd1, 4'd14, 4'd10, 4'd9, 4'd12, 4'd13};
    logic [7:0]  d_a  [8] = '{8'hFF, 8'h7F, 8'h01, 8'h0F, 8'h80, 8'h80, 8'hFF, 8'hFF};
    logic [7:0]  d_b  [8] = '{8'h01, 8'h01, 8'h02, 8'h11, 8'h03, 8'h03, 8'h01, 8'h01};
    logic [11:0] d_exp[8] = '{12'hA00, 12'h580, 12'h9FF, 12'h1FF, 12'h1F0, 12'h010, 12'h001, 12'h200};

    initial begin
        int lat, stall, n_acc, out0, guard;
        logic [11:0] obs, e1;
        logic [3:0] op;
        logic [7:0] a, b, a2, b2;
        logic accepted;

        reset         = 1'b1;
        bus.in_valid  = 1'b0;
        bus.A         = '0;
        bus.B         = '0;
        bus.opcode    = '0;
        bus.out_ready = 1'b0;

        // Reset state.
        repeat (3) @(negedge clk);
        #4;
        check("rst_in_ready", 64'(bus.in_ready), 64'd0);
        check("rst_out_valid", 64'(bus.out_valid), 64'd0);
        check("rst_result", 64'(bus.result), 64'd0);
        check("rst_flags", 64'({bus.carryout, bus.overflow, bus.zero, bus.negative}), 64'd0);
        check("rst_state", 64'(dbg_state), 64'(IDLE));
        @(negedge clk);
        reset = 1'b0;
        #4;
        check("rst_release_ready", 64'(bus.in_ready), 64'd1);

        // Directed vectors with fixed expected values and latency.
        for (int i = 0; i < 8; i++) begin
            do_op(d_op[i], d_a[i], d_b[i], lat, stall, obs);
            check($sformatf("dir%0d_value", i), 64'(obs), 64'(d_exp[i]));
            check($sformatf("dir%0d_latency", i), 64'(lat), (d_op[i] == 4'd14) ? 64'd9 : 64'd1);
            check($sformatf("dir%0d_stall", i), 64'(stall), (d_op[i] == 4'd14) ? 64'd8 : 64'd0);
        end

        // Random single ops with latency check.
        for (int i = 0; i < 16; i++) begin
            op = 4'($urandom_range(0, 15));
            a  = 8'($urandom_range(0, 255));
            b  = 8'($urandom_range(0, 255));
            do_op(op, a, b, lat, stall, obs);
            check("rnd_value", 64'(obs), 64'(model(op, a, b)));
            check("rnd_latency", 64'(lat), (op == 4'd14) ? 64'd9 : 64'd1);
        end

        // Back-to-back ADDs held by out_ready low for 3 cycles.
        out0 = n_out;
        a  = 8'h3C; b  = 8'h55;
        a2 = 8'hC8; b2 = 8'h64;
        e1 = model(4'd0, a, b);
        @(negedge clk);
        bus.in_valid  = 1'b1;
        bus.opcode    = 4'd0;
        bus.A         = a;
        bus.B         = b;
        bus.out_ready = 1'b0;
        #4;
        check("b2b_first_ready", 64'(bus.in_ready), 64'd1);
        if (bus.in_ready) exp_q.push_back(e1);
        @(negedge clk);
        bus.A = a2;
        bus.B = b2;
        for (int k = 0; k < 3; k++) begin
            #4;
            check("b2b_hold_ready", 64'(bus.in_ready), 64'd0);
            check("b2b_hold_valid", 64'(bus.out_valid), 64'd1);
            check("b2b_hold_result", 64'(bus.result), 64'(e1[7:0]));
            @(negedge clk);
        end
        bus.out_ready = 1'b1;
        #4;
        check("b2b_release_ready", 64'(bus.in_ready), 64'd1);
        if (bus.in_ready) exp_q.push_back(model(4'd0, a2, b2));
        @(negedge clk);
        bus.in_valid = 1'b0;
        #4;
        check("b2b_second_valid", 64'(bus.out_valid), 64'd1);
        @(negedge clk);
        bus.out_ready = 1'b0;
        #4;
        check("b2b_idle_valid", 64'(bus.out_valid), 64'd0);
        check("b2b_count", 64'(n_out - out0), 64'd2);
        check("b2b_queue_empty", 64'(exp_q.size()), 64'd0);

        // Reset asserted 4 cycles into a multiply.
        out0 = n_out;
        @(negedge clk);
        bus.in_valid  = 1'b1;
        bus.opcode    = 4'd14;
        bus.A         = 8'hA5;
        bus.B         = 8'h3B;
        bus.out_ready = 1'b1;
        #4;
        check("rmul_accept", 64'(bus.in_ready), 64'd1);
        @(negedge clk);
        bus.in_valid = 1'b0;
        repeat (3) @(negedge clk);
        #2;
        check("rmul_state_before", 64'(dbg_state), 64'(MUL));
        reset = 1'b1;
        #1;
        check("rmul_out_valid", 64'(bus.out_valid), 64'd0);
        check("rmul_in_ready", 64'(bus.in_ready), 64'd0);
        check("rmul_state", 64'(dbg_state), 64'(IDLE));
        check("rmul_result", 64'(bus.result), 64'd0);
        repeat (2) @(negedge clk);
        reset = 1'b0;
        #4;
        check("rmul_release_ready", 64'(bus.in_ready), 64'd1);
        repeat (12) @(negedge clk);
        #4;
        check("rmul_no_output", 64'(n_out - out0), 64'd0);
        do_op(4'd0, 8'h12, 8'h34, lat, stall, obs);
        check("rmul_next_value", 64'(obs), 64'(model(4'd0, 8'h12, 8'h34)));
        check("rmul_next_latency", 64'(lat), 64'd1);

        // Randomized stream with random back-pressure.
        out0     = n_out;
        n_acc    = 0;
        accepted = 1'b0;
        bus.in_valid = 1'b0;
        for (int cyc = 0; cyc < 400; cyc++) begin
            @(negedge clk);
            if (accepted) bus.in_valid = 1'b0;
            if (!bus.in_valid) begin
                bus.opcode = ($urandom_range(0, 5) == 0) ? 4'd14 : 4'($urandom_range(0, 15));
                bus.A      = 8'($urandom_range(0, 255));
                bus.B      = 8'($urandom_range(0, 255));
                bus.in_valid = ($urandom_range(0, 3) != 0);
            end
            bus.out_ready = ($urandom_range(0, 3) != 0);
            #4;
            accepted = bus.in_valid && bus.in_ready;
            if (accepted) begin
                exp_q.push_back(model(bus.opcode, bus.A, bus.B));
                n_acc++;
            end
        end
        @(negedge clk);
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b1;
        guard = 0;
        while (exp_q.size() != 0 && guard < 40) begin
            @(negedge clk);
            guard++;
        end
        #4;
        check("stream_drain", 64'(exp_q.size()), 64'd0);
        check("stream_count", 64'(n_out - out0), 64'(n_acc));

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/alu_pipe.md
ALU_PIPE -- requirements
Module: alu_pipe

Interface
REQ-001 SHALL have parameter NUMBITS, default 32, datapath width, legal range 4..64.
REQ-002 SHALL have parameter SHW, default $clog2(NUMBITS), shift-amount width taken from B[SHW-1:0].
REQ-003 clk  input  1  sole clock, all state updates on rising edge.
REQ-004 reset  input  1  asynchronous, active-high reset.
REQ-005 in_valid  input  1  operand/opcode presented.
REQ-006 in_ready  output  1  block accepts operation this cycle.
REQ-007 A, B  input  NUMBITS  operands.
REQ-008 opcode  input  4  operation select.
REQ-009 out_valid  output  1  result and flags valid.
REQ-010 out_ready  input  1  consumer takes result this cycle.
REQ-011 result  output  NUMBITS  registered result.
REQ-012 carryout, overflow, zero, negative  output  1 each  registered flags.

Function
REQ-013 Opcodes SHALL be: 0 ADD, 1 SUB, 2 ADDS (signed), 3 SUBS (signed), 4 AND, 5 OR, 6 NOT A, 7 A<<1, 8 SLL A by B[SHW-1:0], 9 SRL, 10 SRA, 11 XOR, 12 SLT signed (result 1/0), 13 SLTU, 14 MUL (low NUMBITS bits of A*B, unsigned), 15 PASS B.
REQ-014 Transfer on input SHALL occur when in_valid && in_ready; on output when out_valid && out_ready.
REQ-015 FSM states SHALL be IDLE, MUL, OUT.
REQ-016 IDLE: in_ready=1, out_valid=0; accept of opcode 14 -> MUL, any other accept -> OUT.
REQ-017 MUL: in_ready=0, out_valid=0; iterative shift-add, exactly NUMBITS cycles, then -> OUT.
REQ-018 OUT: out_valid=1, result/flags held stable until transfer; in_ready = out_ready.
REQ-019 OUT with out_ready and in_valid SHALL accept new op same cycle (-> OUT or MUL per opcode); out_ready without in_valid -> IDLE.
REQ-020 Latency: non-MUL result valid 1 cycle after accept; MUL NUMBITS+1 cycles after accept; non-MUL throughput 1 op/cycle under out_ready=1.
REQ-021 carryout: ADD = carry from MSB; SUB = borrow (1 when A<B unsigned); all other ops 0.
REQ-022 overflow: ADDS/SUBS signed two's-complement overflow; all other ops 0.
REQ-023 zero SHALL be (result==0); negative SHALL be result[NUMBITS-1]; both for every op.
REQ-024 Shift amounts >= NUMBITS SHALL be impossible by SHW width; SRA SHALL replicate A[NUMBITS-1].
REQ-025 Inputs in_valid/A/B/opcode SHALL be ignored whenever in_ready=0.

Reset
REQ-026 reset assertion SHALL immediately force state IDLE, out_valid=0, result=0, all flags=0, multiply counter/accumulator cleared.
REQ-027 reset mid-MUL or mid-OUT SHALL discard the operation; no output transfer follows.
REQ-028 in_ready SHALL be 0 while reset is high and 1 in the first cycle after deassertion.

Structure
REQ-029 Package alu_pkg SHALL hold opcode constants (OP_ADD..OP_PASSB) and FSM state encoding.
REQ-030 Iterative multiplier SHALL be sub-module alu_mul_seq (start, done, NUMBITS-parametrised); remaining ops combinational in alu_pipe, registered at OUT entry.

Verification (NUMBITS=8)
REQ-031 ADD A=0xFF B=0x01 -> result 0x00, carryout 1, zero 1, overflow 0, out_valid cycle after accept.
REQ-032 ADDS A=0x7F B=0x01 -> 0x80, overflow 1, negative 1, carryout 0; SUB A=0x01 B=0x02 -> 0xFF, carryout 1.
REQ-033 MUL A=0x0F B=0x11 -> 0xFF, in_ready 0 for 8 cycles, out_valid exactly 9 cycles after accept.
REQ-034 SRA A=0x80 B=0x03 -> 0xF0; SRL same -> 0x10; SLT A=0xFF B=0x01 -> 0x01, SLTU -> 0x00.
REQ-035 Back-to-back ADDs with out_ready low 3 cycles -> result held, in_ready 0, no op lost or duplicated after release.
REQ-036 reset asserted 4 cycles into MUL -> out_valid 0 immediately, in_ready 1 first cycle after release, next ADD completes normally.
